hex_display_sequencer: RTL
==========================

Name: hex_display_sequencer

Overview:
- Drives the six DE10-Lite HEX displays (active-low segments, bit order gfedcba) from a binary value taken in over a valid/ready handshake.
- Converts the value to decimal BCD with a serial double-dabble. Hex mode skips the conversion.
- Time-shares one bcd_code_converter instance across all six digits, one digit per cycle, into shadow registers.
- Commits all six digits at once, then applies leading-zero blanking, overflow dashes and per-digit blinking.

Parameters:
- BLINK_DIV, 12_500_000: clock cycles per blink-phase toggle. At 50 MHz this gives a 2 Hz blink.

Ports:
- clk  input  1  system clock (50 MHz)
- reset_n  input  1  asynchronous, active-low reset
- value_in  input  20  binary value to display
- value_valid  input  1  value_in, hex_mode and blank_lz are valid
- value_ready  output  1  block is idle and can accept a value
- hex_mode  input  1  0 = decimal, 1 = hexadecimal; sampled at handshake
- blank_lz  input  1  blank leading zeros; sampled at handshake
- blink_mask  input  6  bit i set = HEXi blinks; sampled live every cycle
- hex0..hex5  output  7 each  segment drive for HEX0 (least significant) to HEX5, active-low

Behaviour:
- Reset (async assert, sync deassert assumed upstream):
  - state IDLE, bit counter 0, digit index 0
  - shadow and committed digits = SEG_BLANK (7'h7F)
  - hex0..hex5 = 7'h7F
  - blink counter 0, blink_phase 0
  - value_ready = 1 (combinational: state == IDLE)
- Handshake: a value is accepted on the rising edge where value_valid && value_ready. value_in, hex_mode and blank_lz are latched on that edge. value_valid while busy is ignored; nothing is queued.
- FSM, state IDLE:
  - On accept, go to CONVERT if hex_mode = 0, else go to UPDATE.
- FSM, state CONVERT:
  - Exactly 20 cycles of double-dabble on a 24-bit BCD plus 20-bit binary shift register.
  - Each cycle: add 3 to every BCD nibble >= 5, then shift left by 1.
  - Then go to UPDATE.
- FSM, state UPDATE:
  - 6 cycles, digit index i = 0..5.
  - The decoder input is nibble i, taken from BCD in decimal mode or from value_in[4i+3:4i] in hex mode.
  - shadow[i] gets the decoder output unless one of the overrides below applies.
- Overrides in UPDATE, highest priority first:
  - Decimal overflow: latched value > 999999 makes every shadow digit SEG_DASH (7'h3F).
  - Hex mode, i = 5: SEG_BLANK.
  - blank_lz = 1, i >= 1, nibble i and all higher displayed nibbles are 0: SEG_BLANK. HEX0 is never lead-blanked.
- FSM, state COMMIT:
  - 1 cycle: committed[0..5] <= shadow[0..5], all simultaneously. Then go to IDLE.
- Latency, counted in rising edges from the accept edge until new data appears on the outputs:
  - decimal mode: 28
  - hex mode: 8
  - Output registers follow committed with 1 cycle of delay.
  - hexN never shows a partially updated set.
- Blink:
  - Free-running counter 0..BLINK_DIV-1. blink_phase toggles on wrap.
  - Each cycle: hexN <= (blink_phase && blink_mask[N]) ? 7'h7F : committed[N].
  - Blinking runs in every FSM state. A blink_mask change takes effect on the next edge.
- Reset mid-operation: everything returns to reset values and the in-flight value is lost. Previously displayed digits are blanked.
- Back-to-back: value_ready rises in the cycle after COMMIT, so a new accept is possible on the next edge.

Decomposition:
- Package hex_display_pkg:
  - SEG_BLANK = 7'h7F, SEG_DASH = 7'h3F
  - NUM_DIGITS = 6, MAX_DEC = 20'd999999, CONV_CYCLES = 20
  - state encoding: IDLE, CONVERT, UPDATE, COMMIT
- Sub-module bin2bcd_serial: start/done, 20-bit in, 24-bit BCD out, one shift per cycle.
- One instance of the existing bcd_code_converter, shared by all six digits.

Test Plan:
- Reset released with no stimulus -> all hexN = 7'h7F, value_ready = 1.
- value_in = 123456, decimal, blank_lz = 0 -> after 28 edges:
  - hex5..hex0 = 1111001, 0100100, 0110000, 0011001, 0010010, 0000010
  - value_ready low for 27 cycles
- value_in = 42, decimal, blank_lz = 1 -> hex5..hex2 = 7'h7F, hex1 = 0011001, hex0 = 0100100. With blank_lz = 0 -> hex5..hex2 = 1000000.
- value_in = 1000000, decimal -> all six = 7'h3F. value_in = 20'hABCDE, hex_mode = 1 -> after 8 edges:
  - hex5 = 7'h7F
  - hex4..hex0 = 0001000, 0000011, 1000110, 0100001, 0000110
- BLINK_DIV = 4, blink_mask = 6'b000001, 8 displayed -> hex0 alternates 0000000 / 7'h7F every 4 cycles, other digits steady. A second value_valid pulse during CONVERT is ignored and the display shows only the first value.
- reset_n pulsed low at cycle 10 of CONVERT -> outputs blank immediately, value_ready = 1, FSM IDLE. A subsequent 7 in decimal mode displays correctly.

Source files
------------

// File: rtl/hex_display_pkg.sv
// hex_display_pkg: shared constants and FSM encoding for the HEX display sequencer
package hex_display_pkg;
    localparam logic [6:0]  SEG_BLANK   = 7'h7F;
    localparam logic [6:0]  SEG_DASH    = 7'h3F;
    localparam int          NUM_DIGITS  = 6;
    localparam int          CONV_CYCLES = 20;
    localparam logic [19:0] MAX_DEC     = 20'd999999;
    localparam logic [1:0]  IDLE        = 2'd0;
    localparam logic [1:0]  CONVERT     = 2'd1;
    localparam logic [1:0]  UPDATE      = 2'd2;
    localparam logic [1:0]  COMMIT      = 2'd3;
endpackage

// File: rtl/bcd_code_converter.sv
// bcd_code_converter: 4-bit code to active-low gfedcba seven-segment pattern (0-F)
module bcd_code_converter (
    input  logic [3:0] code,
    output logic [6:0] seg
);
    // Glyph lookup, hex digits A-F included for hex mode
    always_comb begin
        seg = 7'h7F;
        case (code)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = 7'h7F;
        endcase
    end
endmodule

// File: rtl/hex_display_sequencer_bin2bcd.sv
// bin2bcd_serial: serial double-dabble, 20-bit binary to 6-digit BCD, one shift per cycle
module bin2bcd_serial
    import hex_display_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [19:0] bin,
    output logic        done,
    output logic [23:0] bcd
);
    logic [43:0] sr;
    logic [23:0] adj;
    logic [4:0]  cnt;
    logic        busy;

    assign bcd  = sr[43:20];
    assign done = busy && cnt == 5'(CONV_CYCLES - 1);

    // Add 3 to every BCD nibble that is 5 or more before the shift
    always_comb begin
        adj = sr[43:20];
        for (int j = 0; j < NUM_DIGITS; j++)
            adj[4*j +: 4] = sr[20+4*j +: 4] >= 4'd5 ? sr[20+4*j +: 4] + 4'd3 : sr[20+4*j +: 4];
    end

    // Load on start, then shift CONV_CYCLES times
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sr   <= '0;
            cnt  <= '0;
            busy <= 1'b0;
        end else if (start) begin
            sr   <= {24'd0, bin};
            cnt  <= '0;
            busy <= 1'b1;
        end else if (busy) begin
            sr   <= {adj[22:0], sr[19:0], 1'b0};
            cnt  <= done ? 5'd0 : cnt + 5'd1;
            busy <= !done;
        end
    end
endmodule

// File: rtl/hex_display_sequencer.sv
// hex_display_sequencer: handshake-fed 6-digit HEX display driver with blanking, dashes and blink
module hex_display_sequencer
    import hex_display_pkg::*;
#(
    parameter int BLINK_DIV = 12_500_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [19:0] value_in,
    input  logic        value_valid,
    output logic        value_ready,
    input  logic        hex_mode,
    input  logic        blank_lz,
    input  logic [5:0]  blink_mask,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic [6:0]  hex5
);
    localparam int BW = $clog2(BLINK_DIV + 1);

    logic [1:0]    state;
    logic [19:0]   val;
    logic          hm, blz, accept, done, upper_zero, phase;
    logic [2:0]    idx;
    logic [23:0]   bcd, digits;
    logic [3:0]    nib;
    logic [6:0]    seg, next_seg;
    logic [6:0]    shadow [NUM_DIGITS];
    logic [6:0]    committed [NUM_DIGITS];
    logic [6:0]    hex_q [NUM_DIGITS];
    logic [BW-1:0] bcnt;

    assign value_ready = state == IDLE;
    assign accept      = value_valid && value_ready;
    assign digits      = hm ? {4'h0, val} : bcd;
    assign nib         = digits[{idx, 2'b00} +: 4];
    assign upper_zero  = (digits >> {idx, 2'b00}) == 24'd0;
    assign {hex5, hex4, hex3, hex2, hex1, hex0} = {hex_q[5], hex_q[4], hex_q[3], hex_q[2], hex_q[1], hex_q[0]};

    bin2bcd_serial u_bin2bcd (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (accept && !hex_mode),
        .bin     (value_in),
        .done    (done),
        .bcd     (bcd)
    );

    bcd_code_converter u_conv (
        .code (nib),
        .seg  (seg)
    );

    // Override priority: overflow dashes, unused hex digit, leading-zero blank
    always_comb begin
        next_seg = (!hm && val > MAX_DEC) ? SEG_DASH :
                   (hm && idx == 3'd5) ? SEG_BLANK :
                   (blz && idx != 3'd0 && upper_zero) ? SEG_BLANK : seg;
    end

    // Sequencing: accept, convert, walk the six digits, commit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            val   <= '0;
            hm    <= 1'b0;
            blz   <= 1'b0;
            idx   <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    val   <= value_in;
                    hm    <= hex_mode;
                    blz   <= blank_lz;
                    idx   <= '0;
                    state <= hex_mode ? UPDATE : CONVERT;
                end
                CONVERT: if (done) state <= UPDATE;
                UPDATE: begin
                    idx   <= idx == 3'd5 ? 3'd0 : idx + 3'd1;
                    state <= idx == 3'd5 ? COMMIT : UPDATE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Shadow fill during UPDATE and atomic transfer to committed during COMMIT
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow[i]    <= SEG_BLANK;
                committed[i] <= SEG_BLANK;
            end
        end else begin
            if (state == UPDATE) shadow[idx] <= next_seg;
            if (state == COMMIT)
                for (int i = 0; i < NUM_DIGITS; i++) committed[i] <= shadow[i];
        end
    end

    // Free-running blink phase generator
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bcnt  <= '0;
            phase <= 1'b0;
        end else begin
            bcnt  <= bcnt == BW'(BLINK_DIV - 1) ? '0 : bcnt + 1'b1;
            phase <= bcnt == BW'(BLINK_DIV - 1) ? !phase : phase;
        end
    end

    // Output registers with live blink masking
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) hex_q[i] <= SEG_BLANK;
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++)
                hex_q[i] <= (phase && blink_mask[i]) ? SEG_BLANK : committed[i];
        end
    end
endmodule
